mem_wb_stage: RTL and testbench
===============================

// Module: mem_wb_stage
// PURPOSE
//  Memory-access/write-back stage directly downstream of the ALU. Consumes the ALU result, store data,
//  write flag, flags, branch decision and SP update. Performs LD/ST/PUSH/POP on a 16-bit req/ack
//  data bus with a timeout, then issues one write-back pulse to register file, SP, flags and PC logic.
// PARAMETERS
//  TIMEOUT    255  max cycles in REQ without mem_ack before abort with bus_err (1..2^TO_W-1)
//  TO_W       8    timeout counter width
// PORTS
//  clk            in   1   clock, all state on rising edge
//  rst            in   1   reset, asynchronous, active-high
//  en             in   1   one-cycle pulse: ALU outputs valid, start a transaction
//  alu_control    in   8   opcode (OPC_* from cpu_constants.vh) of the instruction in flight
//  alu_out        in   16  ALU result / effective address
//  alu_mem_data   in   16  store/push data from ALU
//  alu_write      in   1   ALU write-enable for rD
//  alu_flags      in   4   ALU flags (FLAG_BIT_* layout)
//  should_branch  in   1   ALU branch decision
//  sp_in          in   16  new SP value from ALU (PUSH/POP)
//  rd_sel         in   4   destination register index
//  mem_addr       out  16  bus address
//  mem_wdata      out  16  bus write data
//  mem_we         out  1   1 = write, 0 = read
//  mem_req        out  1   bus request, held until ack or timeout
//  mem_rdata      in   16  bus read data, valid with mem_ack
//  mem_ack        in   1   bus acknowledge, one cycle
//  rf_we          out  1   register-file write strobe
//  rf_waddr       out  4   register-file write index
//  rf_wdata       out  16  register-file write data
//  sp_we          out  1   SP write strobe
//  sp_wdata       out  16  SP write data
//  flags_we       out  1   flags register write strobe
//  flags_out      out  4   flags to register
//  branch_taken   out  1   PC load strobe
//  branch_target  out  16  PC load value
//  bus_err        out  1   transaction aborted by timeout
//  done           out  1   write-back cycle (one-cycle pulse)
//  busy           out  1   state != IDLE
// BEHAVIOUR
//  - Reset: state=IDLE, counter=0; every output 0 (addresses/data 16'h0000). Async reset during REQ
//    drops mem_req immediately; the transaction is lost, no write-back.
//  - States: IDLE -> (en) REQ if opcode in {LD,ST,PUSH,POP} else WB; REQ -> WB on mem_ack or timeout;
//    WB -> IDLE unconditionally. en outside IDLE is ignored (no queueing).
//  - On accepted en all inputs are latched; downstream outputs derive only from latched values.
//  - REQ: mem_req=1; mem_addr=latched alu_out; mem_we=1 for ST/PUSH, 0 for LD/POP;
//    mem_wdata=latched alu_mem_data for ST/PUSH, else 0. Bus outputs stable throughout REQ.
//    mem_ack sampled at an edge in REQ -> WB next cycle; LD/POP capture mem_rdata at that edge.
//    mem_ack in IDLE/WB ignored. Counter clears on entry to REQ, +1 per REQ cycle with no ack;
//    counter==TIMEOUT with no ack -> WB with bus_err. Ack and timeout same edge: ack wins, bus_err=0.
//  - WB (exactly one cycle): done=1. Outputs 0 outside WB (except bus outputs in REQ, busy).
//    LD:   rf_we=1, rf_wdata=read data.   POP: rf_we=1, rf_wdata=read data, sp_we=1, sp_wdata=sp_in.
//    ST:   no strobes.                    PUSH: sp_we=1, sp_wdata=sp_in.
//    JMP:  branch_taken=should_branch, branch_target=alu_out; rf_we=0.
//    other: rf_we=alu_write, rf_wdata=alu_out.
//    rf_waddr=rd_sel whenever rf_we=1.
//    flags_we=1 with flags_out=alu_flags for all opcodes except LD,ST,PUSH,POP,JMP,SET,MOV.
//    bus_err=1 suppresses rf_we, sp_we, branch_taken (flags_we also 0).
//  - Latency: non-memory: en at edge k -> done in cycle after k (1 cycle).
//    Memory: ack at edge j -> done in cycle after j; zero-wait bus (ack first REQ cycle) = 2 cycles total.
//  - Back-to-back: en accepted at the edge leaving WB is ignored; earliest next en is the edge in IDLE.
// TESTING
//  1 ADD: en, alu_out=16'h1234, alu_write=1, rd_sel=3, alu_flags=4'b0001 -> next cycle done=1,
//    rf_we=1, rf_waddr=3, rf_wdata=16'h1234, flags_we=1, flags_out=4'b0001.
//  2 LD addr 16'h0040, ack after 3 REQ cycles with rdata 16'hBEEF -> mem_req high 3 cycles, mem_we=0,
//    mem_addr=16'h0040; then done, rf_wdata=16'hBEEF, flags_we=0.
//  3 PUSH: alu_out=16'h7FFE, alu_mem_data=16'hA5A5, sp_in=16'h7FFE, ack first cycle -> mem_we=1,
//    mem_wdata=16'hA5A5; WB sp_we=1, sp_wdata=16'h7FFE, rf_we=0.
//  4 ST with no ack, TIMEOUT=4 -> mem_req high 5 cycles, then done=1, bus_err=1, all strobes 0;
//    repeat with ack on the timeout edge -> bus_err=0.
//  5 JMP should_branch=1, alu_out=16'h0100 -> branch_taken=1, target 16'h0100; should_branch=0 -> 0.
//  6 rst asserted mid-REQ -> mem_req falls without a clock edge, no done; en pulse during busy ignored.

Source files
------------

// File: rtl/mem_wb_stage.sv
// Memory-access / write-back stage: runs LD/ST/PUSH/POP on a req/ack bus with timeout,
// then emits a single write-back pulse to register file, SP, flags and PC logic.
module mem_wb_stage #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TO_W    = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_en,
  input  logic [7:0]  i_alu_control,
  input  logic [15:0] i_alu_out,
  input  logic [15:0] i_alu_mem_data,
  input  logic        i_alu_write,
  input  logic [3:0]  i_alu_flags,
  input  logic        i_should_branch,
  input  logic [15:0] i_sp_in,
  input  logic [3:0]  i_rd_sel,
  output logic [15:0] o_mem_addr,
  output logic [15:0] o_mem_wdata,
  output logic        o_mem_we,
  output logic        o_mem_req,
  input  logic [15:0] i_mem_rdata,
  input  logic        i_mem_ack,
  output logic        o_rf_we,
  output logic [3:0]  o_rf_waddr,
  output logic [15:0] o_rf_wdata,
  output logic        o_sp_we,
  output logic [15:0] o_sp_wdata,
  output logic        o_flags_we,
  output logic [3:0]  o_flags_out,
  output logic        o_branch_taken,
  output logic [15:0] o_branch_target,
  output logic        o_bus_err,
  output logic        o_done,
  output logic        o_busy
);

  localparam int unsigned DW = 16;
  localparam int unsigned OW = 8;

  localparam logic [OW-1:0] OPC_LD   = 8'h10;
  localparam logic [OW-1:0] OPC_ST   = 8'h11;
  localparam logic [OW-1:0] OPC_PUSH = 8'h12;
  localparam logic [OW-1:0] OPC_POP  = 8'h13;
  localparam logic [OW-1:0] OPC_JMP  = 8'h20;
  localparam logic [OW-1:0] OPC_SET  = 8'h30;
  localparam logic [OW-1:0] OPC_MOV  = 8'h31;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WB} state_t;

  typedef struct packed {
    logic          done;
    logic          bus_err;
    logic          rf_we;
    logic [3:0]    rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic          sp_we;
    logic [DW-1:0] sp_wdata;
    logic          flags_we;
    logic [3:0]    flags_out;
    logic          branch_taken;
    logic [DW-1:0] branch_target;
  } wb_t;

  state_t          r_state;
  logic [TO_W-1:0] r_cnt;
  logic [OW-1:0]   r_opc;
  logic [DW-1:0]   r_alu_out;
  logic            r_alu_write;
  logic [3:0]      r_flags;
  logic            r_branch;
  logic [DW-1:0]   r_sp;
  logic [3:0]      r_rd;
  logic [DW-1:0]   r_mem_addr;
  logic [DW-1:0]   r_mem_wdata;
  logic            r_mem_we;
  logic            r_mem_req;
  logic            r_busy;
  wb_t             r_wb;

  logic w_in_mem;
  logic w_in_wr;
  logic w_timeout;

  function automatic logic is_mem(input logic [OW-1:0] opc);
    return (opc == OPC_LD) || (opc == OPC_ST) || (opc == OPC_PUSH) || (opc == OPC_POP);
  endfunction

  // Write-back payload for one instruction; a bus error kills every strobe.
  function automatic wb_t wb_calc(input logic [OW-1:0] opc, input logic [DW-1:0] alu_out,
                                  input logic [DW-1:0] rdata, input logic alu_write,
                                  input logic [3:0] flags, input logic br,
                                  input logic [DW-1:0] sp, input logic [3:0] rd,
                                  input logic err);
    wb_t w;
    w         = '0;
    w.done    = 1'b1;
    w.bus_err = err;
    if (!err) begin
      case (opc)
        OPC_LD: begin
          w.rf_we = 1'b1; w.rf_waddr = rd; w.rf_wdata = rdata;
        end
        OPC_POP: begin
          w.rf_we = 1'b1; w.rf_waddr = rd; w.rf_wdata = rdata;
          w.sp_we = 1'b1; w.sp_wdata = sp;
        end
        OPC_ST: ;
        OPC_PUSH: begin
          w.sp_we = 1'b1; w.sp_wdata = sp;
        end
        OPC_JMP: begin
          w.branch_taken = br; w.branch_target = alu_out;
        end
        default: begin
          w.rf_we = alu_write;
          if (alu_write) begin
            w.rf_waddr = rd; w.rf_wdata = alu_out;
          end
        end
      endcase
      if (!is_mem(opc) && opc != OPC_JMP && opc != OPC_SET && opc != OPC_MOV) begin
        w.flags_we = 1'b1; w.flags_out = flags;
      end
    end
    return w;
  endfunction

  assign w_in_mem  = is_mem(i_alu_control);
  assign w_in_wr   = (i_alu_control == OPC_ST) || (i_alu_control == OPC_PUSH);
  assign w_timeout = (r_cnt == TO_W'(TIMEOUT));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_opc       <= '0;
      r_alu_out   <= '0;
      r_alu_write <= 1'b0;
      r_flags     <= '0;
      r_branch    <= 1'b0;
      r_sp        <= '0;
      r_rd        <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_we    <= 1'b0;
      r_mem_req   <= 1'b0;
      r_busy      <= 1'b0;
      r_wb        <= '0;
    end else begin
      r_wb <= '0;
      case (r_state)
        S_IDLE: begin
          if (i_en) begin
            r_opc       <= i_alu_control;
            r_alu_out   <= i_alu_out;
            r_alu_write <= i_alu_write;
            r_flags     <= i_alu_flags;
            r_branch    <= i_should_branch;
            r_sp        <= i_sp_in;
            r_rd        <= i_rd_sel;
            r_busy      <= 1'b1;
            if (w_in_mem) begin
              r_state     <= S_REQ;
              r_cnt       <= '0;
              r_mem_req   <= 1'b1;
              r_mem_addr  <= i_alu_out;
              r_mem_we    <= w_in_wr;
              r_mem_wdata <= w_in_wr ? i_alu_mem_data : '0;
            end else begin
              r_state <= S_WB;
              r_wb    <= wb_calc(i_alu_control, i_alu_out, '0, i_alu_write, i_alu_flags,
                                 i_should_branch, i_sp_in, i_rd_sel, 1'b0);
            end
          end
        end
        S_REQ: begin
          // Ack takes priority over a timeout landing on the same edge.
          if (i_mem_ack || w_timeout) begin
            r_state     <= S_WB;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_wb        <= wb_calc(r_opc, r_alu_out, i_mem_ack ? i_mem_rdata : '0, r_alu_write,
                                   r_flags, r_branch, r_sp, r_rd, !i_mem_ack);
          end else begin
            r_cnt <= r_cnt + TO_W'(1);
          end
        end
        S_WB: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_mem_addr      = r_mem_addr;
  assign o_mem_wdata     = r_mem_wdata;
  assign o_mem_we        = r_mem_we;
  assign o_mem_req       = r_mem_req;
  assign o_busy          = r_busy;
  assign o_done          = r_wb.done;
  assign o_bus_err       = r_wb.bus_err;
  assign o_rf_we         = r_wb.rf_we;
  assign o_rf_waddr      = r_wb.rf_waddr;
  assign o_rf_wdata      = r_wb.rf_wdata;
  assign o_sp_we         = r_wb.sp_we;
  assign o_sp_wdata      = r_wb.sp_wdata;
  assign o_flags_we      = r_wb.flags_we;
  assign o_flags_out     = r_wb.flags_out;
  assign o_branch_taken  = r_wb.branch_taken;
  assign o_branch_target = r_wb.branch_target;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: directed transactions push expected write-back
// payloads; a negedge monitor pops and compares them whenever done pulses.
module tb_mem_wb_stage;

  localparam int unsigned TIMEOUT = 4;

  localparam logic [7:0] OPC_ADD  = 8'h01;
  localparam logic [7:0] OPC_SUB  = 8'h02;
  localparam logic [7:0] OPC_LD   = 8'h10;
  localparam logic [7:0] OPC_ST   = 8'h11;
  localparam logic [7:0] OPC_PUSH = 8'h12;
  localparam logic [7:0] OPC_POP  = 8'h13;
  localparam logic [7:0] OPC_JMP  = 8'h20;
  localparam logic [7:0] OPC_SET  = 8'h30;

  typedef struct packed {
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [15:0] rf_wdata;
    logic        sp_we;
    logic [15:0] sp_wdata;
    logic        flags_we;
    logic [3:0]  flags_out;
    logic        branch_taken;
    logic [15:0] branch_target;
    logic        bus_err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [7:0]  alu_control = '0;
  logic [15:0] alu_out = '0, alu_mem_data = '0, sp_in = '0, mem_rdata = '0;
  logic        alu_write = 1'b0, should_branch = 1'b0, mem_ack = 1'b0;
  logic [3:0]  alu_flags = '0, rd_sel = '0;
  logic [15:0] mem_addr, mem_wdata, rf_wdata, sp_wdata, branch_target;
  logic        mem_we, mem_req, rf_we, sp_we, flags_we, branch_taken, bus_err, done, busy;
  logic [3:0]  rf_waddr, flags_out;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t exp_q[$];
  string name_q[$];

  mem_wb_stage #(.TIMEOUT(TIMEOUT), .TO_W(8)) dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_alu_control(alu_control), .i_alu_out(alu_out),
    .i_alu_mem_data(alu_mem_data), .i_alu_write(alu_write), .i_alu_flags(alu_flags),
    .i_should_branch(should_branch), .i_sp_in(sp_in), .i_rd_sel(rd_sel),
    .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .o_mem_we(mem_we), .o_mem_req(mem_req),
    .i_mem_rdata(mem_rdata), .i_mem_ack(mem_ack), .o_rf_we(rf_we), .o_rf_waddr(rf_waddr),
    .o_rf_wdata(rf_wdata), .o_sp_we(sp_we), .o_sp_wdata(sp_wdata), .o_flags_we(flags_we),
    .o_flags_out(flags_out), .o_branch_taken(branch_taken), .o_branch_target(branch_target),
    .o_bus_err(bus_err), .o_done(done), .o_busy(busy)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic rwe, input logic [3:0] wa, input logic [15:0] wd,
                              input logic swe, input logic [15:0] sd, input logic fwe,
                              input logic [3:0] fo, input logic bt, input logic [15:0] tgt,
                              input logic err);
    exp_t e;
    e = '{rf_we: rwe, rf_waddr: wa, rf_wdata: wd, sp_we: swe, sp_wdata: sd, flags_we: fwe,
          flags_out: fo, branch_taken: bt, branch_target: tgt, bus_err: err};
    return e;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  initial begin : monitor
    exp_t act;
    exp_t e;
    string nm;
    logic prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (done) begin
        act = '{rf_we: rf_we, rf_waddr: rf_waddr, rf_wdata: rf_wdata, sp_we: sp_we,
                sp_wdata: sp_wdata, flags_we: flags_we, flags_out: flags_out,
                branch_taken: branch_taken, branch_target: branch_target, bus_err: bus_err};
        n_tests++;
        if (prev_done) begin
          n_fail++;
          $display("FAIL done_pulse: done high two cycles in a row, expected one");
        end else if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_done: got done=1 with payload %h, expected no done", act);
        end else begin
          e  = exp_q.pop_front();
          nm = name_q.pop_front();
          if (act !== e) begin
            n_fail++;
            $display("FAIL wb_%s: got %h, expected %h", nm, act, e);
          end
        end
      end
      prev_done = done;
    end
  end

  task automatic issue(input logic [7:0] opc, input logic [15:0] ao, input logic [15:0] md,
                       input logic wr, input logic [3:0] fl, input logic br,
                       input logic [15:0] sp, input logic [3:0] rd);
    alu_control = opc; alu_out = ao; alu_mem_data = md; alu_write = wr;
    alu_flags = fl; should_branch = br; sp_in = sp; rd_sel = rd;
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
  endtask

  // Drives the bus side of a memory transaction; ack_at < 0 means never ack.
  task automatic run_bus(input string nm, input int ack_at, input logic [15:0] rdata,
                         input int exp_cycles, input logic [15:0] addr, input logic we,
                         input logic [15:0] wdata);
    int cycles = 0;
    for (int i = 0; i < 64; i++) begin
      if (!mem_req) break;
      cycles++;
      check({nm, "_bus"}, 64'({mem_addr, mem_wdata, mem_we, busy}), 64'({addr, wdata, we, 1'b1}));
      mem_ack   = (i == ack_at);
      mem_rdata = (i == ack_at) ? rdata : 16'h0;
      @(negedge clk);
    end
    mem_ack = 1'b0;
    mem_rdata = 16'h0;
    check({nm, "_req_cycles"}, 64'(cycles), 64'(exp_cycles));
    check({nm, "_bus_idle"}, 64'({mem_req, mem_we, mem_addr, mem_wdata}), 64'd0);
  endtask

  task automatic expect_wb(input string nm, input exp_t e);
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  initial begin : stim
    repeat (2) @(negedge clk);
    check("reset_outputs",
          64'({mem_req, mem_we, done, busy, rf_we, sp_we, flags_we, branch_taken, bus_err,
               mem_addr, rf_wdata, sp_wdata}), 64'd0);
    check("reset_data", 64'({mem_wdata, branch_target, rf_waddr, flags_out}), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // 1: ADD, one-cycle latency
    expect_wb("add", mk(1, 4'd3, 16'h1234, 0, 16'h0, 1, 4'b0001, 0, 16'h0, 0));
    issue(OPC_ADD, 16'h1234, 16'h0, 1, 4'b0001, 0, 16'h0, 4'd3);
    check("add_latency", 64'({done, busy}), 64'({1'b1, 1'b1}));
    @(negedge clk);
    check("add_idle", 64'({done, busy}), 64'd0);

    // 2: LD with ack on the third REQ cycle
    expect_wb("ld", mk(1, 4'd2, 16'hBEEF, 0, 16'h0, 0, 4'h0, 0, 16'h0, 0));
    issue(OPC_LD, 16'h0040, 16'h9999, 0, 4'hF, 0, 16'h0, 4'd2);
    run_bus("ld", 2, 16'hBEEF, 3, 16'h0040, 0, 16'h0000);
    @(negedge clk);

    // 3: PUSH, zero-wait bus
    expect_wb("push", mk(0, 4'd0, 16'h0, 1, 16'h7FFE, 0, 4'h0, 0, 16'h0, 0));
    issue(OPC_PUSH, 16'h7FFE, 16'hA5A5, 0, 4'h0, 0, 16'h7FFE, 4'd1);
    run_bus("push", 0, 16'h0, 1, 16'h7FFE, 1, 16'hA5A5);
    @(negedge clk);

    // 4: ST timeout, then ack on the timeout edge
    expect_wb("st_timeout", mk(0, 4'd0, 16'h0, 0, 16'h0, 0, 4'h0, 0, 16'h0, 1));
    issue(OPC_ST, 16'h0200, 16'h1111, 1, 4'h3, 0, 16'h0, 4'd7);
    run_bus("st_timeout", -1, 16'h0, TIMEOUT + 1, 16'h0200, 1, 16'h1111);
    @(negedge clk);
    expect_wb("st_ack_edge", mk(0, 4'd0, 16'h0, 0, 16'h0, 0, 4'h0, 0, 16'h0, 0));
    issue(OPC_ST, 16'h0202, 16'h2222, 0, 4'h0, 0, 16'h0, 4'd0);
    run_bus("st_ack_edge", TIMEOUT, 16'h0, TIMEOUT + 1, 16'h0202, 1, 16'h2222);
    @(negedge clk);

    // 5: JMP taken / not taken
    expect_wb("jmp_taken", mk(0, 4'd0, 16'h0, 0, 16'h0, 0, 4'h0, 1, 16'h0100, 0));
    issue(OPC_JMP, 16'h0100, 16'h0, 1, 4'hF, 1, 16'h0, 4'd9);
    @(negedge clk);
    expect_wb("jmp_not", mk(0, 4'd0, 16'h0, 0, 16'h0, 0, 4'h0, 0, 16'h0100, 0));
    issue(OPC_JMP, 16'h0100, 16'h0, 0, 4'h0, 0, 16'h0, 4'd0);
    @(negedge clk);

    // POP, SET (no flags), SUB with alu_write=0
    expect_wb("pop", mk(1, 4'd4, 16'h55AA, 1, 16'h8000, 0, 4'h0, 0, 16'h0, 0));
    issue(OPC_POP, 16'h7FFE, 16'h0, 0, 4'h0, 0, 16'h8000, 4'd4);
    run_bus("pop", 1, 16'h55AA, 2, 16'h7FFE, 0, 16'h0000);
    @(negedge clk);
    expect_wb("set", mk(1, 4'd6, 16'h00C3, 0, 16'h0, 0, 4'h0, 0, 16'h0, 0));
    issue(OPC_SET, 16'h00C3, 16'h0, 1, 4'hA, 0, 16'h0, 4'd6);
    @(negedge clk);
    expect_wb("sub_nowr", mk(0, 4'd0, 16'h0, 0, 16'h0, 1, 4'h4, 0, 16'h0, 0));
    issue(OPC_SUB, 16'h4321, 16'h0, 0, 4'h4, 0, 16'h0, 4'd8);
    @(negedge clk);

    // 6a: async reset mid-REQ, no write-back
    issue(OPC_LD, 16'h0300, 16'h0, 0, 4'h0, 0, 16'h0, 4'd1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check("rst_mid_req", 64'({mem_req, busy, mem_addr}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // 6b: en during REQ and on the edge leaving WB is ignored
    expect_wb("ld_busy", mk(1, 4'd5, 16'h1357, 0, 16'h0, 0, 4'h0, 0, 16'h0, 0));
    issue(OPC_LD, 16'h0080, 16'h0, 0, 4'h0, 0, 16'h0, 4'd5);
    alu_control = OPC_ADD; alu_out = 16'hFFFF; alu_write = 1'b1; en = 1'b1;
    @(negedge clk);
    en = 1'b0; mem_ack = 1'b1; mem_rdata = 16'h1357;
    @(negedge clk);
    mem_ack = 1'b0; mem_rdata = 16'h0;
    check("ld_busy_wb", 64'({done, busy, mem_req}), 64'({1'b1, 1'b1, 1'b0}));
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    check("en_leaving_wb", 64'({busy, done, mem_req}), 64'd0);
    repeat (3) @(negedge clk);

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
